// File: rtl/branch_predictor_if.sv
// Fetch/resolve port bundle between the pipeline (master) and the branch predictor (slave).
interface branch_predictor_if;
    logic [31:0] fetch_pc;
    logic [31:0] pc;
    logic        pred_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    modport slave (
        input  fetch_pc,
        input  upd_valid,
        input  upd_pc,
        input  upd_taken,
        input  upd_target,
        input  upd_mispredict,
        output pc,
        output pred_taken,
        output branch_cnt,
        output mispredict_cnt
    );

    modport master (
        output fetch_pc,
        output upd_valid,
        output upd_pc,
        output upd_taken,
        output upd_target,
        output upd_mispredict,
        input  pc,
        input  pred_taken,
        input  branch_cnt,
        input  mispredict_cnt
    );
endinterface

// File: rtl/branch_predictor.sv
// 64-entry direct-mapped BTB with 2-bit counters plus branch/mispredict counters.
// Table is built only when BRANCH_PREDICT_EN is defined; otherwise pc = fetch_pc + 4.
module branch_predictor (
    input  logic              clk,
    input  logic              rst,
    branch_predictor_if.slave bp
);
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispredict_cnt;
    logic [31:0] w_seq_pc;

    assign w_seq_pc = bp.fetch_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_cnt     <= 32'd0;
            r_mispredict_cnt <= 32'd0;
        end else if (bp.upd_valid) begin
            r_branch_cnt <= r_branch_cnt + 32'd1;
            if (bp.upd_mispredict) begin
                r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
            end
        end
    end

    assign bp.branch_cnt     = r_branch_cnt;
    assign bp.mispredict_cnt = r_mispredict_cnt;

`ifdef BRANCH_PREDICT_EN
    localparam int ENTRIES = 64;

    logic [5:0]                  w_lk_idx;
    logic [23:0]                 w_lk_tag;
    logic                        w_lk_hit;
    logic                        w_pred;
    logic [5:0]                  w_up_idx;
    logic [23:0]                 w_up_tag;
    logic                        w_up_hit;
    logic [1:0]                  w_up_ctr;
    logic [1:0]                  w_ctr_sat;
    logic [ENTRIES-1:0]          w_valid_vec;
    logic [ENTRIES-1:0][1:0]     w_ctr_vec;
    logic [23:0]                 r_tag    [ENTRIES];
    logic [31:0]                 r_target [ENTRIES];
    logic                        w_unused_lsb;

    assign w_lk_idx = bp.fetch_pc[7:2];
    assign w_lk_tag = bp.fetch_pc[31:8];
    assign w_up_idx = bp.upd_pc[7:2];
    assign w_up_tag = bp.upd_pc[31:8];

    // Lookup reads pre-edge contents, so a same-cycle update is not bypassed.
    assign w_lk_hit      = w_valid_vec[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_pred        = w_lk_hit && w_ctr_vec[w_lk_idx][1];
    assign bp.pred_taken = w_pred;
    assign bp.pc         = w_pred ? r_target[w_lk_idx] : w_seq_pc;

    assign w_up_hit = w_valid_vec[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_up_ctr = w_ctr_vec[w_up_idx];

    always_comb begin
        w_ctr_sat = w_up_ctr;
        if (bp.upd_taken) begin
            if (w_up_ctr != 2'd3) begin
                w_ctr_sat = w_up_ctr + 2'd1;
            end
        end else if (w_up_ctr != 2'd0) begin
            w_ctr_sat = w_up_ctr - 2'd1;
        end
    end

    // A taken update either refreshes a hit or allocates on a miss; both write tag and target.
    always_ff @(posedge clk) begin
        if (!rst && bp.upd_valid && bp.upd_taken) begin
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= bp.upd_target;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic       r_valid;
            logic [1:0] r_ctr;
            logic       w_sel;

            assign w_sel = bp.upd_valid && (w_up_idx == 6'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_ctr   <= 2'd1;
                end else if (w_sel) begin
                    if (w_up_hit) begin
                        r_ctr <= w_ctr_sat;
                    end else if (bp.upd_taken) begin
                        r_valid <= 1'b1;
                        r_ctr   <= 2'd2;
                    end
                end
            end

            assign w_valid_vec[gi] = r_valid;
            assign w_ctr_vec[gi]   = r_ctr;
        end
    endgenerate

    assign w_unused_lsb = ^{bp.fetch_pc[1:0], bp.upd_pc[1:0]};
`else
    logic w_unused_upd;

    assign bp.pred_taken = 1'b0;
    assign bp.pc         = w_seq_pc;
    assign w_unused_upd  = ^{bp.upd_pc, bp.upd_taken, bp.upd_target};
`endif

endmodule
